// File: rtl/fpga_cmd_rx_pkg.sv
// Shared FPGA defines: command codes, receiver FSM encoding and the OFF-mode reset constant.
package fpga_cmd_rx_pkg;

    localparam int FPGA_CMD_SET_CONFREG  = 1;
    localparam int FPGA_CMD_TRACE_ENABLE = 2;

    // All-ones configuration selects major mode 7 (OFF); truncated to the configured width.
    localparam logic [31:0] FPGA_CONF_OFF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } fpga_rx_state_t;

endpackage

// File: rtl/fpga_cmd_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fpga_cmd_rx.sv
// SPI command receiver from the ARM: shifts in CMD+DATA frames, commits configuration
// and trace-enable writes, counts framing errors and returns a status word on miso.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for chip select to fall; spck edges ignored
// ST_SHIFT  | frame in progress: mosi shifted in, status shifted out
// ST_COMMIT | one cycle: decode command and update outputs
// ST_ERROR  | one cycle: wrong frame length, bump error counter
module fpga_cmd_rx
    import fpga_cmd_rx_pkg::*;
#(
    parameter int CMD_W  = 4,
    parameter int DATA_W = 12,
    parameter int CONF_W = 9,
    parameter int ERR_W  = 4
) (
    input  logic              ck_1356meg,
    input  logic              rst,
    input  logic              ncs,
    input  logic              spck,
    input  logic              mosi,
    output logic              miso,
    output logic [CONF_W-1:0] conf_word,
    output logic              trace_enable,
    output logic              conf_update,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int STAT_W  = ERR_W + 1 + CONF_W;
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

    fpga_rx_state_t       state;
    logic                 ncs_s, spck_s, mosi_s;
    logic                 ncs_d, spck_d, mosi_q;
    logic                 ncs_fall_q, ncs_rise_q, spck_rise_q, spck_fall_q;
    logic [CNT_W-1:0]     bit_cnt, cnt_next;
    logic [FRAME_W-1:0]   shift_sr, rb_sr, status_word;
    logic [STAT_W+FRAME_W-1:0] stat_ext;
    logic [CMD_W-1:0]     cmd;
    logic [CONF_W-1:0]    conf_new;

    sync2 #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(ck_1356meg), .rst(rst), .d(ncs),  .q(ncs_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_spck (.clk(ck_1356meg), .rst(rst), .d(spck), .q(spck_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(ck_1356meg), .rst(rst), .d(mosi), .q(mosi_s));

    // Registered edge pulses; mosi is delayed alongside so it lines up with spck_rise_q.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            ncs_d       <= 1'b1;
            spck_d      <= 1'b0;
            mosi_q      <= 1'b0;
            ncs_fall_q  <= 1'b0;
            ncs_rise_q  <= 1'b0;
            spck_rise_q <= 1'b0;
            spck_fall_q <= 1'b0;
        end else begin
            ncs_d       <= ncs_s;
            spck_d      <= spck_s;
            mosi_q      <= mosi_s;
            ncs_fall_q  <= ncs_d & ~ncs_s;
            ncs_rise_q  <= ~ncs_d & ncs_s;
            spck_rise_q <= ~spck_d & spck_s;
            spck_fall_q <= spck_d & ~spck_s;
        end
    end

    // Bit count including the edge in this cycle, so a simultaneous ncs rise sees it; saturates.
    always_comb begin
        cnt_next = bit_cnt;
        if (spck_rise_q && (bit_cnt != CNT_MAX))
            cnt_next = bit_cnt + 1'b1;
    end

    // Status word {err_cnt, trace_enable, conf_word, zero pad}, keeping the top FRAME_W bits.
    assign stat_ext    = {err_cnt, trace_enable, conf_word, {FRAME_W{1'b0}}};
    assign status_word = FRAME_W'(stat_ext >> STAT_W);
    assign cmd         = shift_sr[FRAME_W-1 -: CMD_W];
    assign conf_new    = CONF_W'(shift_sr);
    assign miso        = (state == ST_SHIFT) ? rb_sr[FRAME_W-1] : 1'b0;

    // Frame FSM with registered outputs.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_sr     <= '0;
            rb_sr        <= '0;
            conf_word    <= CONF_W'(FPGA_CONF_OFF);
            trace_enable <= 1'b0;
            conf_update  <= 1'b0;
            err_cnt      <= '0;
        end else begin
            conf_update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ncs_fall_q) begin
                        state    <= ST_SHIFT;
                        bit_cnt  <= '0;
                        shift_sr <= '0;
                        rb_sr    <= status_word;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt <= cnt_next;
                    if (spck_rise_q)
                        shift_sr <= {shift_sr[FRAME_W-2:0], mosi_q};
                    if (spck_fall_q)
                        rb_sr <= {rb_sr[FRAME_W-2:0], 1'b0};
                    if (ncs_rise_q)
                        state <= (cnt_next == CNT_FRAME) ? ST_COMMIT : ST_ERROR;
                end
                ST_COMMIT: begin
                    if (cmd == CMD_W'(FPGA_CMD_SET_CONFREG)) begin
                        conf_word   <= conf_new;
                        conf_update <= (conf_new != conf_word);
                    end else if (cmd == CMD_W'(FPGA_CMD_TRACE_ENABLE)) begin
                        trace_enable <= shift_sr[0];
                    end
                    state <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (err_cnt != {ERR_W{1'b1}})
                        err_cnt <= err_cnt + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cmd_rx.sv
// Directed bench for fpga_cmd_rx: SPI frames driven bit by bit, outputs checked against hand-computed values.
module tb_fpga_cmd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ncs = 1'b1;
    logic       spck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [8:0] conf_word;
    logic       trace_enable;
    logic       conf_update;
    logic [3:0] err_cnt;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;
    int upd_base;
    logic [31:0] rd;

    always #5 clk = ~clk;

    fpga_cmd_rx dut (
        .ck_1356meg  (clk),
        .rst         (rst),
        .ncs         (ncs),
        .spck        (spck),
        .mosi        (mosi),
        .miso        (miso),
        .conf_word   (conf_word),
        .trace_enable(trace_enable),
        .conf_update (conf_update),
        .err_cnt     (err_cnt)
    );

    always @(posedge clk) if (!rst && conf_update) upd_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives nbits MSB-first with ncs left low; miso is sampled before each rising spck.
    task automatic send_bits(input logic [31:0] data, input int nbits, output logic [31:0] rdata);
        rdata = '0;
        ncs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            repeat (4) @(negedge clk);
            rdata = {rdata[30:0], miso};
            spck = 1'b1;
            repeat (8) @(negedge clk);
            spck = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic end_frame();
        ncs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] data, input int nbits);
        logic [31:0] r;
        send_bits(data, nbits, r);
        end_frame();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        ncs = 1'b1;
        spck = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_conf", conf_word, 9'h1FF);
        check("rst_trace", trace_enable, 1'b0);
        check("rst_err", err_cnt, 4'd0);
        check("rst_miso", miso, 1'b0);
        check("rst_upd", conf_update, 1'b0);

        // spck activity while idle must be ignored
        repeat (3) begin
            spck = 1'b1; repeat (6) @(negedge clk);
            spck = 1'b0; repeat (6) @(negedge clk);
        end

        // 0x10C2 with exact commit latency
        upd_base = upd_cnt;
        send_bits(32'h10C2, 16, r);
        ncs = 1'b1;
        repeat (4) @(negedge clk);
        check("lat_before", conf_word, 9'h1FF);
        @(negedge clk);
        check("lat_conf", conf_word, 9'h0C2);
        check("lat_upd", conf_update, 1'b1);
        repeat (10) @(negedge clk);
        check("upd_once", upd_cnt - upd_base, 1);
        check("c2_err", err_cnt, 4'd0);
        check("idle_miso", miso, 1'b0);

        // 0x2001 returns status and sets trace enable
        upd_base = upd_cnt;
        send_bits(32'h2001, 16, rd);
        end_frame();
        check("readback", rd, 32'h0308);
        check("te_set", trace_enable, 1'b1);
        check("te_conf", conf_word, 9'h0C2);
        check("te_noupd", upd_cnt - upd_base, 0);

        // unknown command
        upd_base = upd_cnt;
        frame(32'h70FF, 16);
        check("unk_conf", conf_word, 9'h0C2);
        check("unk_te", trace_enable, 1'b1);
        check("unk_err", err_cnt, 4'd0);
        check("unk_noupd", upd_cnt - upd_base, 0);

        // same conf value rewritten: no update pulse
        upd_base = upd_cnt;
        frame(32'h10C2, 16);
        check("same_conf", conf_word, 9'h0C2);
        check("same_noupd", upd_cnt - upd_base, 0);

        // reset mid-frame after 8 bits of 0x10AA
        send_bits(32'h10, 8, r);
        pulse_reset();
        check("mid_conf", conf_word, 9'h1FF);
        check("mid_err", err_cnt, 4'd0);
        check("mid_te", trace_enable, 1'b0);
        upd_base = upd_cnt;
        frame(32'h1055, 16);
        check("post_conf", conf_word, 9'h055);
        check("post_upd", upd_cnt - upd_base, 1);

        // last spck rise and ncs rise in the same cycle still count 16 bits
        send_bits(32'h1133 >> 1, 15, r);
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        spck = 1'b1;
        ncs = 1'b1;
        repeat (12) @(negedge clk);
        spck = 1'b0;
        repeat (8) @(negedge clk);
        check("simul_conf", conf_word, 9'h133);
        check("simul_err", err_cnt, 4'd0);

        // framing errors and saturation
        pulse_reset();
        frame(32'h10C2 >> 1, 15);
        frame(32'h10C2 << 1, 17);
        check("err_two", err_cnt, 4'd2);
        check("err_conf", conf_word, 9'h1FF);
        for (int k = 0; k < 16; k++) frame(32'h0, (k % 2 == 0) ? 3 : 18);
        check("err_sat", err_cnt, 4'd15);
        check("err_te", trace_enable, 1'b0);
        check("err_conf2", conf_word, 9'h1FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
